sn74ls11_tester: RTL and testbench
==================================

Name: sn74ls11_tester

Overview:
- Self-running hardware tester for a triple 3-input AND device (SN74LS11 pin-out: 1A/1B/1C..3A/3B/3C in, 1Y..3Y out).
- Drives all 8 input combinations onto the device, waits a settle interval, samples the three Y outputs and compares them against expected AND results.
- Reports pass/fail, error count and a per-pattern failure map.
- Sits opposite the gate under test: its outputs feed the gate inputs, and its inputs read the gate outputs.

Parameters:
- SETTLE_CYCLES, 4, clock cycles between driving a pattern and sampling Y; legal range >= 1.
- CNT_W, 8, width of the internal settle counter; must hold SETTLE_CYCLES-1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a run when idle or done.
- out_1A, out_1B, out_1C  output  1 each  drive to gate 1 inputs.
- out_2A, out_2B, out_2C  output  1 each  drive to gate 2 inputs.
- out_3A, out_3B, out_3C  output  1 each  drive to gate 3 inputs.
- in_1Y, in_2Y, in_3Y  input  1 each  gate outputs read back.
- busy  output  1  high while a run is in progress.
- done  output  1  high after a run completes; held until next start or reset.
- pass  output  1  valid while done=1; 1 iff err_count==0.
- err_count  output  5  total mismatching Y bits in the run (0..24).
- fail_vec  output  8  bit v set if any Y mismatched on pattern v.
- first_fail  output  3  index of the lowest failing pattern; 0 if none.

Behaviour:
- One clock; reset is synchronous and active-high. Clock port is clk and reset port is rst.
- Reset: state=IDLE. All out_* = 0; busy, done and pass = 0; err_count, fail_vec and first_fail = 0. Reset mid-run aborts immediately with the same values.
- Pattern v (3-bit, 0..7), all drives registered:
  - Gate 1 {A,B,C} = v.
  - Gate 2 {A,B,C} = ~v.
  - Gate 3 {A,B,C} = (v+3) mod 8.
  - A is the MSB of each vector.
- Expected outputs: Y1 = &v (1 only at v=7); Y2 = &~v (1 only at v=0); Y3 = &(v+3) (1 only at v=4).
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE/DONE with start=1:
  - Clear err_count, fail_vec, first_fail, pass and done.
  - Set v=0 and drive pattern 0.
  - Set cnt = SETTLE_CYCLES-1, busy=1, go to SETTLE.
- SETTLE: if cnt==0 go to CHECK, else cnt decrements. Duration is exactly SETTLE_CYCLES cycles.
- CHECK (one cycle): sample in_1Y..in_3Y and compare against expected.
  - err_count increases by the number of mismatching bits.
  - On any mismatch, set fail_vec[v]; if this is the first failing pattern, first_fail = v.
  - If v<7: v increments, drive the new pattern, cnt = SETTLE_CYCLES-1, go to SETTLE.
  - If v==7: go to DONE with busy=0, done=1, pass=(final err_count==0), all out_* = 0.
- Latency: done rises exactly 8*(SETTLE_CYCLES+1) cycles after the edge that samples start (40 cycles at default).
- start while busy is ignored.
- start in DONE restarts the run; done drops on the next edge.
- start and rst high together: reset wins.
- err_count cannot overflow (maximum 24 < 32).
- in_*Y are sampled only in CHECK and ignored otherwise. The inputs are treated as synchronous: the gate under test is combinational on our own drives, and the settle interval covers its propagation delay.

Test Plan:
- Good AND model connected, pulse start -> busy=1 for 40 cycles; then done=1, pass=1, err_count=0, fail_vec=8'h00, first_fail=0.
- in_1Y stuck at 0 -> done, pass=0, err_count=1, fail_vec=8'h80, first_fail=7.
- in_2Y stuck at 1 -> err_count=7, fail_vec=8'hFE, first_fail=1.
- Y1 and Y3 wires swapped -> err_count=4, fail_vec=8'h90, first_fail=4.
- rst asserted during pattern 3 -> next cycle state IDLE, all outputs 0. A new start then gives a full 40-cycle run with correct results.
- start pulsed again mid-run at cycle 15 -> ignored, done still at cycle 40. start pulsed in DONE -> results cleared, second run completes with identical results.

Source files
------------

// File: rtl/sn74ls11_tester.sv
// rtl/sn74ls11_tester.sv - self-running tester for a triple 3-input AND gate (SN74LS11 pin-out)
// Walks all eight patterns, settles, samples the Y outputs and accumulates a failure report.
module sn74ls11_tester #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       out_1A,
  output logic       out_1B,
  output logic       out_1C,
  output logic       out_2A,
  output logic       out_2B,
  output logic       out_2C,
  output logic       out_3A,
  output logic       out_3B,
  output logic       out_3C,
  input  logic       in_1Y,
  input  logic       in_2Y,
  input  logic       in_3Y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic [7:0] fail_vec,
  output logic [2:0] first_fail
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state, state_nx;
  logic [2:0]       v, v_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [8:0]       drv, drv_nx;
  logic             busy_nx, done_nx, pass_nx;
  logic [4:0]       err_nx, err_sum;
  logic [7:0]       fail_vec_nx;
  logic [2:0]       first_fail_nx;
  logic [2:0]       mism;

  // Packed drive word: [8:6] gate 1, [5:3] gate 2, [2:0] gate 3, A in the MSB of each.
  function automatic logic [8:0] pattern(input logic [2:0] p);
    logic [2:0] p3;
    p3 = p + 3'd3;
    return {p, ~p, p3};
  endfunction

  // Expected Y in the same order as the read-back word {Y1, Y2, Y3}.
  function automatic logic [2:0] expected_y(input logic [2:0] p);
    logic [2:0] p3;
    logic [2:0] pn;
    p3 = p + 3'd3;
    pn = ~p;
    return {&p, &pn, &p3};
  endfunction

  assign mism    = {in_1Y, in_2Y, in_3Y} ^ expected_y(v);
  assign err_sum = err_count + 5'(mism[0]) + 5'(mism[1]) + 5'(mism[2]);

  always_comb begin
    state_nx      = state;
    v_nx          = v;
    cnt_nx        = cnt;
    drv_nx        = drv;
    busy_nx       = busy;
    done_nx       = done;
    pass_nx       = pass;
    err_nx        = err_count;
    fail_vec_nx   = fail_vec;
    first_fail_nx = first_fail;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          err_nx        = '0;
          fail_vec_nx   = '0;
          first_fail_nx = '0;
          pass_nx       = 1'b0;
          done_nx       = 1'b0;
          v_nx          = 3'd0;
          drv_nx        = pattern(3'd0);
          cnt_nx        = CNT_LOAD;
          busy_nx       = 1'b1;
          state_nx      = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt == '0) state_nx = CHECK;
        else           cnt_nx   = cnt - 1'b1;
      end
      CHECK: begin
        err_nx = err_sum;
        if (|mism) begin
          fail_vec_nx[v] = 1'b1;
          // Patterns are walked in ascending order, so the first hit is the lowest index.
          if (fail_vec == '0) first_fail_nx = v;
        end
        if (v != 3'd7) begin
          v_nx     = v + 3'd1;
          drv_nx   = pattern(v + 3'd1);
          cnt_nx   = CNT_LOAD;
          state_nx = SETTLE;
        end else begin
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
          pass_nx  = (err_sum == '0);
          drv_nx   = '0;
          state_nx = DONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      v          <= '0;
      cnt        <= '0;
      drv        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_vec   <= '0;
      first_fail <= '0;
    end else begin
      state      <= state_nx;
      v          <= v_nx;
      cnt        <= cnt_nx;
      drv        <= drv_nx;
      busy       <= busy_nx;
      done       <= done_nx;
      pass       <= pass_nx;
      err_count  <= err_nx;
      fail_vec   <= fail_vec_nx;
      first_fail <= first_fail_nx;
    end
  end

  assign {out_1A, out_1B, out_1C} = drv[8:6];
  assign {out_2A, out_2B, out_2C} = drv[5:3];
  assign {out_3A, out_3B, out_3C} = drv[2:0];

endmodule

// File: tb/tb_sn74ls11_tester.sv
// tb/tb_sn74ls11_tester.sv - scoreboard bench for sn74ls11_tester with a fault-injecting gate model
// Stimulus pushes expected reports; a negedge monitor checks drives, run length and reports.
module tb_sn74ls11_tester;

  localparam int S   = 4;
  localparam int RUN = 8 * (S + 1);

  logic clk = 1'b0;
  logic rst, start;
  logic out_1A, out_1B, out_1C, out_2A, out_2B, out_2C, out_3A, out_3B, out_3C;
  logic in_1Y, in_2Y, in_3Y;
  logic busy, done, pass;
  logic [4:0] err_count;
  logic [7:0] fail_vec;
  logic [2:0] first_fail;

  // Fault controls: bit0=Y1, bit1=Y2, bit2=Y3.
  logic [2:0] s0, s1;
  logic       swap13;
  logic [2:0] y_ideal;

  typedef struct {
    int err;
    int fv;
    int ff;
    int ps;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   run_len = 0;
  logic done_prev = 1'b0;

  always #5 clk = ~clk;

  sn74ls11_tester #(.SETTLE_CYCLES(S), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .out_1A(out_1A), .out_1B(out_1B), .out_1C(out_1C),
    .out_2A(out_2A), .out_2B(out_2B), .out_2C(out_2C),
    .out_3A(out_3A), .out_3B(out_3B), .out_3C(out_3C),
    .in_1Y(in_1Y), .in_2Y(in_2Y), .in_3Y(in_3Y),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_vec(fail_vec), .first_fail(first_fail)
  );

  function automatic logic [2:0] fault(input logic [2:0] y, input logic [2:0] f0,
                                       input logic [2:0] f1, input logic sw);
    logic [2:0] t;
    t = sw ? {y[0], y[1], y[2]} : y;
    return (t & ~f0) | f1;
  endfunction

  always_comb begin
    y_ideal = {out_3A & out_3B & out_3C, out_2A & out_2B & out_2C, out_1A & out_1B & out_1C};
  end
  assign {in_3Y, in_2Y, in_1Y} = fault(y_ideal, s0, s1, swap13);

  function automatic exp_t mk(input int err, input int fv, input int ff, input int ps);
    exp_t e;
    e.err = err; e.fv = fv; e.ff = ff; e.ps = ps;
    return e;
  endfunction

  // A 3-input AND of a 3-bit value is 1 exactly when the value is 7.
  function automatic exp_t model(input logic [2:0] f0, input logic [2:0] f1, input logic sw);
    exp_t e;
    logic [2:0] ideal, obs, d;
    e = mk(0, 0, 0, 0);
    for (int v = 0; v < 8; v++) begin
      ideal[0] = (v == 7);
      ideal[1] = ((7 - v) == 7);
      ideal[2] = (((v + 3) % 8) == 7);
      obs = fault(ideal, f0, f1, sw);
      d = ideal ^ obs;
      if (d != 3'b000) begin
        if (e.fv == 0) e.ff = v;
        e.fv = e.fv | (1 << v);
      end
      e.err = e.err + int'(d[0]) + int'(d[1]) + int'(d[2]);
    end
    e.ps = (e.err == 0) ? 1 : 0;
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pulse_start(input bit expect_run, input exp_t e);
    @(posedge clk);
    #1 start = 1'b1;
    if (expect_run) q.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < RUN + 20) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", int'(done), 1);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_pass"}, int'(pass), 0);
    chk({tag, "_err"}, int'(err_count), 0);
    chk({tag, "_fail_vec"}, int'(fail_vec), 0);
    chk({tag, "_first_fail"}, int'(first_fail), 0);
  endtask

  // Monitor: drive pattern every busy cycle, idle drives low, report on rising done.
  initial begin
    int vv, exp_drv, act_drv;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        run_len = 0;
        done_prev = 1'b0;
      end else begin
        act_drv = int'({out_1A, out_1B, out_1C, out_2A, out_2B, out_2C, out_3A, out_3B, out_3C});
        if (busy) begin
          vv = run_len / (S + 1);
          exp_drv = (vv << 6) | ((7 - vv) << 3) | ((vv + 3) % 8);
          chk("drive_pattern", act_drv, exp_drv);
          run_len++;
        end else begin
          chk("drive_idle", act_drv, 0);
        end
        if (done && !done_prev) begin
          chk("run_length", run_len, RUN);
          run_len = 0;
          if (q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = q.pop_front();
            chk("err_count", int'(err_count), e.err);
            chk("fail_vec", int'(fail_vec), e.fv);
            chk("first_fail", int'(first_fail), e.ff);
            chk("pass", int'(pass), e.ps);
            chk("busy_at_done", int'(busy), 0);
          end
        end
        done_prev = done;
      end
    end
  end

  initial begin
    exp_t good;
    rst = 1'b1; start = 1'b0;
    s0 = 3'b000; s1 = 3'b000; swap13 = 1'b0;
    good = mk(0, 0, 0, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_cleared("reset");

    pulse_start(1'b1, good);
    @(negedge clk);
    chk("busy_after_start", int'(busy), 1);
    wait_done();

    s0 = 3'b001;
    pulse_start(1'b1, mk(1, 8'h80, 7, 0));
    wait_done();

    s0 = 3'b000; s1 = 3'b010;
    pulse_start(1'b1, mk(7, 8'hFE, 1, 0));
    wait_done();

    s1 = 3'b000; swap13 = 1'b1;
    pulse_start(1'b1, mk(4, 8'h90, 4, 0));
    wait_done();

    // Restart from DONE with the same fault: report clears, then repeats.
    pulse_start(1'b1, mk(4, 8'h90, 4, 0));
    @(negedge clk);
    chk("restart_done_drop", int'(done), 0);
    chk("restart_err_clear", int'(err_count), 0);
    chk("restart_fv_clear", int'(fail_vec), 0);
    chk("restart_busy", int'(busy), 1);
    wait_done();

    // start mid-run is ignored; run length is still checked by the monitor.
    swap13 = 1'b0;
    pulse_start(1'b1, good);
    repeat (13) @(posedge clk);
    pulse_start(1'b0, good);
    wait_done();

    // Reset during pattern 3 aborts the run.
    pulse_start(1'b1, good);
    repeat (16) @(posedge clk);
    #1 rst = 1'b1;
    q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_cleared("midrun_reset");
    pulse_start(1'b1, good);
    wait_done();

    for (int i = 0; i < 20; i++) begin
      s0 = 3'($urandom_range(0, 7));
      s1 = 3'($urandom_range(0, 7));
      swap13 = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      pulse_start(1'b1, model(s0, s1, swap13));
      wait_done();
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
